// File: rtl/register_file_sb_if.sv
// Bus bundle for register_file_sb: write port, two read ports and the
// load-reservation scoreboard port.
interface register_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  Reg_Write;
    logic [ADDR_WIDTH-1:0] Write_Register;
    logic [DATA_WIDTH-1:0] Write_Data;
    logic [ADDR_WIDTH-1:0] Read_Register1;
    logic [ADDR_WIDTH-1:0] Read_Register2;
    logic [DATA_WIDTH-1:0] Read_Data1;
    logic [DATA_WIDTH-1:0] Read_Data2;
    logic                  Reserve_En;
    logic [ADDR_WIDTH-1:0] Reserve_Register;
    logic                  Busy1;
    logic                  Busy2;
    logic [ADDR_WIDTH:0]   Busy_Count;

    modport master (
        output Reg_Write, Write_Register, Write_Data,
        output Read_Register1, Read_Register2,
        output Reserve_En, Reserve_Register,
        input  Read_Data1, Read_Data2, Busy1, Busy2, Busy_Count
    );

    modport slave (
        input  Reg_Write, Write_Register, Write_Data,
        input  Read_Register1, Read_Register2,
        input  Reserve_En, Reserve_Register,
        output Read_Data1, Read_Data2, Busy1, Busy2, Busy_Count
    );
endinterface

// File: rtl/register_file_sb.sv
// MIPS general-purpose register file with registered, write-bypassed reads
// and a per-register pending-load scoreboard for hazard detection.
module register_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    register_file_sb_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic                  busy1_q, busy1_d, busy2_q, busy2_d;
    logic [CW-1:0]         count_q, count_d;

    logic wr_ok, rsv_ok, zero1, zero2;

    always_comb begin
        zero1  = (ZERO_REG != 0) && (bus.Read_Register1 == '0);
        zero2  = (ZERO_REG != 0) && (bus.Read_Register2 == '0);
        wr_ok  = bus.Reg_Write  && !((ZERO_REG != 0) && (bus.Write_Register == '0));
        rsv_ok = bus.Reserve_En && !((ZERO_REG != 0) && (bus.Reserve_Register == '0));

        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (bus.Write_Register == ADDR_WIDTH'(i)))
                regs_d[i] = bus.Write_Data;
        end

        // Reservation is applied after the clear so a load issued to the
        // register being written back keeps it pending.
        pending_d = pending_q;
        if (wr_ok)
            pending_d[bus.Write_Register] = 1'b0;
        if (rsv_ok)
            pending_d[bus.Reserve_Register] = 1'b1;

        count_d = '0;
        for (int i = 0; i < DEPTH; i++)
            count_d = count_d + CW'(pending_d[i]);

        // Reading from the post-write image gives the bypass for free.
        rd1_d   = zero1 ? '0 : regs_d[bus.Read_Register1];
        rd2_d   = zero2 ? '0 : regs_d[bus.Read_Register2];
        busy1_d = pending_d[bus.Read_Register1];
        busy2_d = pending_d[bus.Read_Register2];
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            pending_q <= '0;
            rd1_q     <= '0;
            rd2_q     <= '0;
            busy1_q   <= 1'b0;
            busy2_q   <= 1'b0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= regs_d[i];
            pending_q <= pending_d;
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            busy1_q   <= busy1_d;
            busy2_q   <= busy2_d;
            count_q   <= count_d;
        end
    end

    assign bus.Read_Data1 = rd1_q;
    assign bus.Read_Data2 = rd2_q;
    assign bus.Busy1      = busy1_q;
    assign bus.Busy2      = busy2_q;
    assign bus.Busy_Count = count_q;
endmodule

// File: doc/register_file_sb.md
Name: register_file_sb

Overview:
Parametrised general-purpose register file for the single-cycle/pipelined MIPS datapath. Replaces the fixed 32x32 register bank and adds:
- an explicit write enable
- synchronous active-low clear
- a hardwired zero register
- registered read ports with write-to-read bypass
- a per-register pending-write scoreboard that the decode stage uses for load-use hazard detection.

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes and reservations; 0 = register 0 is ordinary

Ports:
Clock  input  1  sole clock; all state updates on rising edge
Reset  input  1  synchronous, active-low reset
Reg_Write  input  1  write enable for the write port
Write_Register  input  ADDR_WIDTH  destination index
Write_Data  input  DATA_WIDTH  data to write
Read_Register1  input  ADDR_WIDTH  read port 1 index
Read_Register2  input  ADDR_WIDTH  read port 2 index
Read_Data1  output  DATA_WIDTH  registered read data, port 1
Read_Data2  output  DATA_WIDTH  registered read data, port 2
Reserve_En  input  1  mark a register as pending (load issued)
Reserve_Register  input  ADDR_WIDTH  index to reserve
Busy1  output  1  registered: Read_Register1 pending at sample time
Busy2  output  1  registered: Read_Register2 pending at sample time
Busy_Count  output  ADDR_WIDTH+1  number of currently pending registers

Behaviour:
- Reset: sampled only on the rising edge of Clock while Reset==0. Reset dominates all other inputs in that cycle. On that edge:
  - all registers clear to 0
  - pending vector clears to 0
  - Read_Data1, Read_Data2, Busy1, Busy2 and Busy_Count go to 0
- Write: on a rising edge with Reset==1 and Reg_Write==1, Registradores[Write_Register] <= Write_Data. When Reg_Write==0, storage is unchanged.
- Zero register (ZERO_REG==1):
  - writes to index 0 are dropped
  - Reserve_En for index 0 is dropped
  - reads of index 0 return 0
  - Busy for index 0 is always 0
- Read latency: 1 cycle. Read_DataN at edge k+1 holds the value of Read_RegisterN sampled at edge k. Outputs are registered and never combinational from the address.
- Bypass: if Reg_Write==1 and Write_Register==Read_RegisterN in the same cycle (and the index is not a zeroed register 0), Read_DataN receives Write_Data, not the old contents. Both ports bypass independently. Both ports may read the same index.
- Scoreboard (pending vector, depth bits):
  - set: Reserve_En==1 sets pending[Reserve_Register]
  - clear: Reg_Write==1 clears pending[Write_Register]
  - simultaneous set and clear of the same index: set wins; the register stays pending, modelling a back-to-back load to the same destination
  - set and clear of different indices both take effect
  - reserving an already-pending register: no change
  - writing a non-pending register: no change
- Busy timing: BusyN is registered alongside Read_DataN. At edge k+1 it reflects pending[Read_RegisterN] after the edge-k updates. A write at edge k to the read index therefore yields BusyN=0, consistent with the bypassed data.
- Busy_Count: registered population count of the pending vector after the edge update. Range 0..depth. It must never wrap, including all depth registers pending when ZERO_REG==0.
- Storage contents are only defined after the first reset. Benches must reset before reading.

Test Plan:
1. Reset clear: write 0xDEADBEEF to r5, then hold Reset=0 for one edge and read r5 → Read_Data1=0, Busy_Count=0. Reset=0 with Reg_Write=1 in the same cycle → the write is ignored.
2. Read latency and enable: write 0x12345678 to r7; Reg_Write=0 with Write_Data=0xFFFFFFFF to r7; read r7 on both ports → both read 0x12345678 exactly one edge after the address is applied.
3. Bypass: in one cycle Reg_Write=1, Write_Register=9, Write_Data=0xA5A5A5A5, Read_Register1=9, Read_Register2=3 (r3 holds 0x11) → next edge Read_Data1=0xA5A5A5A5, Read_Data2=0x11.
4. Zero register (ZERO_REG=1): write 0xFFFFFFFF to r0 and Reserve_En on r0; read r0 → Read_Data1=0, Busy1=0, Busy_Count unchanged. Repeat with ZERO_REG=0 → Read_Data1=0xFFFFFFFF, Busy1=1.
5. Scoreboard:
   - reserve r4, then r6 → Busy_Count 1 then 2; reading r4 gives Busy1=1
   - write r4 → Busy_Count=1, Busy1=0
   - in the same cycle reserve r6 and write r6 → r6 stays pending, Busy_Count=1
   - reserve r4 and write r6 together → Busy_Count=1 (r4 pending, r6 clear)
6. Reset mid-operation: with 3 registers pending and r2=0x55, assert Reset for one edge → Busy_Count=0, Busy1=Busy2=0, r2 reads 0. Normal operation resumes on the next edge.
